// File: rtl/ram_arith_unit_if.sv
// rtl/ram_arith_unit_if.sv - RAM port and arithmetic operand/result bundle for ram_arith_unit
interface ram_arith_unit_if #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 64,
  parameter int ARITH_WIDTH = 16
);
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  rd_addr1;
  logic [ADDR_WIDTH-1:0]  rd_addr2;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [DATA_WIDTH-1:0]  rd_data1;
  logic [DATA_WIDTH-1:0]  rd_data2;

  logic [ARITH_WIDTH-1:0] mul_a;
  logic [ARITH_WIDTH-1:0] mul_b;
  logic [ARITH_WIDTH-1:0] mul_p;
  logic                   mul_ovf;

  logic                   as_mode;
  logic [ARITH_WIDTH-1:0] as_a;
  logic [ARITH_WIDTH-1:0] as_b;
  logic                   as_cin;
  logic [ARITH_WIDTH-1:0] as_sum;
  logic                   as_cout;
  logic                   as_ovf;

  modport master (
    output wr_en, rd_addr1, rd_addr2, wr_addr, wr_data,
    output mul_a, mul_b, as_mode, as_a, as_b, as_cin,
    input  rd_data1, rd_data2, mul_p, mul_ovf, as_sum, as_cout, as_ovf
  );

  modport slave (
    input  wr_en, rd_addr1, rd_addr2, wr_addr, wr_data,
    input  mul_a, mul_b, as_mode, as_a, as_b, as_cin,
    output rd_data1, rd_data2, mul_p, mul_ovf, as_sum, as_cout, as_ovf
  );
endinterface

// File: rtl/ram_arith_unit.sv
// rtl/ram_arith_unit.sv - dual-read/single-write word RAM with combinational signed multiplier and CLA adder/subtractor
module ram_arith_unit #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 100,
  parameter int ARITH_WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ram_arith_unit_if.slave  io_bus
);
  localparam int W     = ARITH_WIDTH;
  localparam int NG    = ARITH_WIDTH / 4;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  // ---------------- RAM ----------------
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic                  w_wr_hit;
  logic                  w_rd1_ok;
  logic                  w_rd2_ok;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd1_idx;
  logic [IDX_W-1:0]      w_rd2_idx;

  assign w_wr_hit  = io_bus.wr_en && (io_bus.wr_addr < DEPTH_A);
  assign w_rd1_ok  = io_bus.rd_addr1 < DEPTH_A;
  assign w_rd2_ok  = io_bus.rd_addr2 < DEPTH_A;
  assign w_wr_idx  = io_bus.wr_addr[IDX_W-1:0];
  assign w_rd1_idx = io_bus.rd_addr1[IDX_W-1:0];
  assign w_rd2_idx = io_bus.rd_addr2[IDX_W-1:0];

  // Every word is a resettable flop so reset clears the whole array at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_mem[w_wr_idx] <= io_bus.wr_data;
    end
  end

  assign io_bus.rd_data1 = w_rd1_ok ? r_mem[w_rd1_idx] : '0;
  assign io_bus.rd_data2 = w_rd2_ok ? r_mem[w_rd2_idx] : '0;

  // ---------------- multiplier ----------------
  logic [2*W-1:0] w_mul_a_ext;
  logic [2*W-1:0] w_mul_b_ext;
  logic [2*W-1:0] w_prod;

  // Low 2W bits of the sign-extended product equal the exact signed product.
  assign w_mul_a_ext    = {{W{io_bus.mul_a[W-1]}}, io_bus.mul_a};
  assign w_mul_b_ext    = {{W{io_bus.mul_b[W-1]}}, io_bus.mul_b};
  assign w_prod         = w_mul_a_ext * w_mul_b_ext;
  assign io_bus.mul_p   = w_prod[W-1:0];
  assign io_bus.mul_ovf = (w_prod != {{W{w_prod[W-1]}}, w_prod[W-1:0]});

  // ---------------- adder / subtractor ----------------
  logic [W-1:0]  w_b_eff;
  logic [W-1:0]  w_g;
  logic [W-1:0]  w_p;
  logic          w_c0;
  logic [NG-1:0] w_grp_g;
  logic [NG-1:0] w_grp_p;
  logic [NG:0]   w_grp_c;
  logic [W:0]    w_c;

  assign w_b_eff = io_bus.as_mode ? ~io_bus.as_b : io_bus.as_b;
  assign w_c0    = io_bus.as_cin ^ io_bus.as_mode;
  assign w_g     = io_bus.as_a & w_b_eff;
  assign w_p     = io_bus.as_a ^ w_b_eff;

  always_comb begin : grp_pg
    w_grp_g = '0;
    w_grp_p = '0;
    for (int k = 0; k < NG; k++) begin
      w_grp_p[k] = &w_p[4*k +: 4];
      w_grp_g[k] = w_g[4*k+3]
                 | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
    end
  end

  // Each group carry is a flat sum of products, so no carry ripples between groups.
  always_comb begin : grp_carry
    logic l_acc;
    logic l_prod;
    w_grp_c    = '0;
    w_grp_c[0] = w_c0;
    for (int k = 0; k < NG; k++) begin
      l_prod = w_c0;
      for (int j = 0; j <= k; j++) begin
        l_prod = l_prod & w_grp_p[j];
      end
      l_acc = l_prod;
      for (int j = 0; j <= k; j++) begin
        l_prod = w_grp_g[j];
        for (int m = j + 1; m <= k; m++) begin
          l_prod = l_prod & w_grp_p[m];
        end
        l_acc = l_acc | l_prod;
      end
      w_grp_c[k+1] = l_acc;
    end
  end

  always_comb begin : bit_carry
    logic l_c;
    w_c = '0;
    for (int k = 0; k < NG; k++) begin
      l_c = w_grp_c[k];
      for (int i = 0; i < 4; i++) begin
        w_c[4*k+i] = l_c;
        l_c = w_g[4*k+i] | (w_p[4*k+i] & l_c);
      end
    end
    w_c[W] = w_grp_c[NG];
  end

  assign io_bus.as_sum  = w_p ^ w_c[W-1:0];
  assign io_bus.as_cout = w_c[W];
  assign io_bus.as_ovf  = w_c[W] ^ w_c[W-1];
endmodule

// File: tb/tb_ram_arith_unit.sv
// tb/tb_ram_arith_unit.sv - scoreboard bench for ram_arith_unit with directed vectors
module tb_ram_arith_unit;
  localparam int K_RD1 = 0, K_RD2 = 1, K_MULP = 2, K_MULOVF = 3;
  localparam int K_SUM = 4, K_COUT = 5, K_ASOVF = 6;

  typedef struct {
    int          kind;
    logic [63:0] value;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [63:0] mon_act;
  logic [15:0] acc;

  ram_arith_unit_if #(.ADDR_WIDTH(13), .DATA_WIDTH(64), .ARITH_WIDTH(16)) bus ();

  ram_arith_unit #(
    .ADDR_WIDTH(13), .DATA_WIDTH(64), .DEPTH(100), .ARITH_WIDTH(16)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input int kind, input logic [63:0] v, input string nm);
    exp_t e;
    e.kind  = kind;
    e.value = v;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [12:0] a, input logic [63:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    nxt();
    bus.wr_en   = 1'b0;
  endtask

  task automatic mul_vec(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] p, input logic ovf, input string nm);
    bus.mul_a = a;
    bus.mul_b = b;
    expect_out(K_MULP, 64'(p), {nm, "_p"});
    expect_out(K_MULOVF, 64'(ovf), {nm, "_ovf"});
    nxt();
  endtask

  task automatic as_vec(input logic mode, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] s, input logic co,
                        input logic ov, input string nm);
    bus.as_mode = mode;
    bus.as_a    = a;
    bus.as_b    = b;
    bus.as_cin  = cin;
    expect_out(K_SUM, 64'(s), {nm, "_sum"});
    expect_out(K_COUT, 64'(co), {nm, "_cout"});
    expect_out(K_ASOVF, 64'(ov), {nm, "_ovf"});
    nxt();
  endtask

  // Monitor: the DUT is combinational on its outputs, so every queued expectation is settled by the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      case (mon_e.kind)
        K_RD1:    mon_act = bus.rd_data1;
        K_RD2:    mon_act = bus.rd_data2;
        K_MULP:   mon_act = 64'(bus.mul_p);
        K_MULOVF: mon_act = 64'(bus.mul_ovf);
        K_SUM:    mon_act = 64'(bus.as_sum);
        K_COUT:   mon_act = 64'(bus.as_cout);
        default:  mon_act = 64'(bus.as_ovf);
      endcase
      checks++;
      if (mon_act !== mon_e.value) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", mon_e.name, mon_act, mon_e.value);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    acc    = '0;
    rst_n  = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.mul_a = 16'd3; bus.mul_b = 16'd5;
    bus.as_mode = 1'b0; bus.as_a = '0; bus.as_b = '0; bus.as_cin = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    expect_out(K_RD1, 64'h0, "reset_rd1");
    expect_out(K_RD2, 64'h0, "reset_rd2");
    expect_out(K_MULP, 64'd15, "mul_during_reset");
    nxt();
    rst_n = 1'b1;
    nxt();

    // Asynchronous clear without a clock edge
    wr(13'd5, 64'hDEAD_BEEF);
    bus.rd_addr1 = 13'd5;
    expect_out(K_RD1, 64'hDEAD_BEEF, "wr_rd5");
    nxt();
    rst_n = 1'b0;
    expect_out(K_RD1, 64'h0, "async_clear");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    nxt();

    // Reset held across an edge with WR_EN high
    rst_n = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 13'd6; bus.wr_data = 64'hAA;
    nxt();
    bus.wr_en = 1'b0;
    rst_n = 1'b1;
    bus.rd_addr1 = 13'd6;
    expect_out(K_RD1, 64'h0, "rst_beats_wr");
    nxt();

    wr(13'd3, 64'd3);
    wr(13'd4, 64'd7);
    bus.rd_addr1 = 13'd3;
    bus.rd_addr2 = 13'd4;
    expect_out(K_RD1, 64'd3, "dual_rd1");
    expect_out(K_RD2, 64'd7, "dual_rd2");
    nxt();
    bus.wr_addr = 13'd3;
    bus.wr_data = 64'hFFFF;
    nxt();
    expect_out(K_RD1, 64'd3, "no_wr_when_disabled");
    nxt();

    wr(13'd100, 64'h1);
    bus.rd_addr1 = 13'd100;
    bus.rd_addr2 = 13'd0;
    expect_out(K_RD1, 64'h0, "oor_read");
    expect_out(K_RD2, 64'h0, "oor_no_alias");
    nxt();
    wr(13'd99, 64'hABC);
    bus.rd_addr1 = 13'd99;
    bus.rd_addr2 = 13'h1FFF;
    expect_out(K_RD1, 64'hABC, "last_word");
    expect_out(K_RD2, 64'h0, "max_addr_read");
    nxt();

    bus.rd_addr1 = 13'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 13'd4; bus.wr_data = 64'h55;
    expect_out(K_RD1, 64'd7, "rdw_old");
    nxt();
    bus.wr_en = 1'b0;
    expect_out(K_RD1, 64'h55, "rdw_new");
    nxt();

    mul_vec(16'd3,    16'd5,    16'd15,    1'b0, "mul_3x5");
    mul_vec(16'hFFFC, 16'd6,    16'hFFE8,  1'b0, "mul_m4x6");
    mul_vec(16'd300,  16'd300,  16'h5F90,  1'b1, "mul_300x300");
    mul_vec(16'h8000, 16'hFFFF, 16'h8000,  1'b1, "mul_min_x_m1");
    mul_vec(16'hFFFF, 16'hFFFF, 16'h0001,  1'b0, "mul_m1xm1");

    as_vec(1'b0, 16'h000B, 16'h0000, 1'b1, 16'h000C, 1'b0, 1'b0, "inc");
    as_vec(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_pos_ovf");
    as_vec(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    as_vec(1'b1, 16'd10,   16'd3,    1'b0, 16'd7,    1'b1, 1'b0, "sub_10_3");
    as_vec(1'b1, 16'd10,   16'd3,    1'b1, 16'd6,    1'b1, 1'b0, "sub_10_3_borrow");
    as_vec(1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, "sub_0_1");
    as_vec(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_neg_ovf");
    as_vec(1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, "add_group_carry");

    // Chained MAC: row [1,2] dot vector [3,4]
    wr(13'd20, 64'd1);
    wr(13'd21, 64'd2);
    wr(13'd22, 64'd3);
    wr(13'd23, 64'd4);
    acc = '0;
    bus.as_mode = 1'b0;
    bus.as_cin  = 1'b0;
    for (int step = 0; step < 2; step++) begin
      bus.rd_addr1 = 13'(20 + step);
      bus.rd_addr2 = 13'(22 + step);
      #1;
      bus.mul_a = bus.rd_data1[15:0];
      bus.mul_b = bus.rd_data2[15:0];
      #1;
      bus.as_a = acc;
      bus.as_b = bus.mul_p;
      #1;
      acc = bus.as_sum;
      expect_out(K_SUM, (step == 0) ? 64'd3 : 64'd11, (step == 0) ? "mac_step1" : "mac_step2");
      nxt();
    end
    wr(13'd11, 64'(acc));
    bus.rd_addr1 = 13'd11;
    expect_out(K_RD1, 64'd11, "mac_mem11");
    nxt();
    nxt();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
